// File: rtl/n_bit_cla_subtractor_pipeline_pkg.sv
// Shared widths for the CLA adder/subtractor datapath slice.
package n_bit_cla_subtractor_pipeline_pkg;

  localparam int DEFAULT_DATA_WID = 32;

  function automatic int half_wid(input int data_wid);
    return data_wid / 2;
  endfunction

endpackage

// File: rtl/n_bit_cla_subtractor_pipeline_cla_adder.sv
// Combinational N-bit carry-lookahead adder; each carry is a flat
// sum-of-products over generate/propagate terms rather than a ripple chain.
module n_bit_cla_subtractor_pipeline_cla_adder #(
  parameter int WID = 16
) (
  input  logic [WID-1:0] in1,
  input  logic [WID-1:0] in2,
  input  logic           carry_in,
  output logic [WID-1:0] sum,
  output logic           carry_out
);

  logic [WID-1:0] gen;
  logic [WID-1:0] prop;
  logic [WID:0]   carry;

  assign gen  = in1 & in2;
  assign prop = in1 ^ in2;

  // c[i+1] = OR_j ( g[j] & p[j+1..i] ) | ( p[0..i] & carry_in )
  always_comb begin
    logic term;
    logic acc;
    carry    = '0;
    carry[0] = carry_in;
    for (int unsigned i = 0; i < WID; i++) begin
      acc = 1'b0;
      for (int unsigned j = 0; j <= i; j++) begin
        term = gen[j];
        for (int unsigned k = j + 1; k <= i; k++) begin
          term = term & prop[k];
        end
        acc = acc | term;
      end
      term = carry_in;
      for (int unsigned k = 0; k <= i; k++) begin
        term = term & prop[k];
      end
      carry[i+1] = acc | term;
    end
  end

  assign sum       = prop ^ carry[WID-1:0];
  assign carry_out = carry[WID];

endmodule

// File: rtl/n_bit_cla_subtractor_pipeline.sv
// Two-stage pipelined subtractor (in1 - in2 - borrow_in) with carry-select
// high half and valid/ready flow control.
module n_bit_cla_subtractor_pipeline
  import n_bit_cla_subtractor_pipeline_pkg::*;
#(
  parameter int DATA_WID = DEFAULT_DATA_WID
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_WID-1:0] in1,
  input  logic [DATA_WID-1:0] in2,
  input  logic                borrow_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WID-1:0] diff,
  output logic                borrow_out,
  output logic                overflow,
  output logic                zero
);

  localparam int HALF_WID = half_wid(DATA_WID);
  localparam int MSB      = DATA_WID - 1;

  logic [DATA_WID-1:0] in1_a;
  logic [DATA_WID-1:0] in2_a;
  logic                borrow_a;
  logic                valid_a;
  logic                adv_b;

  logic [DATA_WID-1:0] in2_inv;
  logic [HALF_WID-1:0] sum_lo;
  logic [HALF_WID-1:0] sum_hi0;
  logic [HALF_WID-1:0] sum_hi1;
  logic                c_lo;
  logic                c_hi0;
  logic                c_hi1;
  logic [DATA_WID-1:0] diff_b;
  logic                borrow_b;
  logic                overflow_b;

  assign adv_b    = ~out_valid | out_ready;
  assign in_ready = ~valid_a | adv_b;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in1_a    <= '0;
      in2_a    <= '0;
      borrow_a <= 1'b0;
      valid_a  <= 1'b0;
    end else if (in_valid && in_ready) begin
      in1_a    <= in1;
      in2_a    <= in2;
      borrow_a <= borrow_in;
      valid_a  <= 1'b1;
    end else if (adv_b) begin
      valid_a  <= 1'b0;
    end
  end

  // a - b - bin == a + ~b + ~bin; the carry out is the inverted borrow
  assign in2_inv = ~in2_a;

  n_bit_cla_subtractor_pipeline_cla_adder #(.WID(HALF_WID)) u_cla_lo (
    .in1       (in1_a[HALF_WID-1:0]),
    .in2       (in2_inv[HALF_WID-1:0]),
    .carry_in  (~borrow_a),
    .sum       (sum_lo),
    .carry_out (c_lo)
  );

  n_bit_cla_subtractor_pipeline_cla_adder #(.WID(HALF_WID)) u_cla_hi0 (
    .in1       (in1_a[DATA_WID-1:HALF_WID]),
    .in2       (in2_inv[DATA_WID-1:HALF_WID]),
    .carry_in  (1'b0),
    .sum       (sum_hi0),
    .carry_out (c_hi0)
  );

  n_bit_cla_subtractor_pipeline_cla_adder #(.WID(HALF_WID)) u_cla_hi1 (
    .in1       (in1_a[DATA_WID-1:HALF_WID]),
    .in2       (in2_inv[DATA_WID-1:HALF_WID]),
    .carry_in  (1'b1),
    .sum       (sum_hi1),
    .carry_out (c_hi1)
  );

  assign diff_b     = {(c_lo ? sum_hi1 : sum_hi0), sum_lo};
  assign borrow_b   = ~(c_lo ? c_hi1 : c_hi0);
  assign overflow_b = (in1_a[MSB] != in2_a[MSB]) && (diff_b[MSB] != in1_a[MSB]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else if (adv_b) begin
      out_valid  <= valid_a;
      diff       <= diff_b;
      borrow_out <= borrow_b;
      overflow   <= overflow_b;
      zero       <= (diff_b == '0);
    end
  end

endmodule

// File: tb/tb_n_bit_cla_subtractor_pipeline.sv
// Scoreboard bench: the driver queues model results on accept, the monitor
// pops and compares them whenever the DUT hands a result over.
module tb_n_bit_cla_subtractor_pipeline;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] d;
    logic         b;
    logic         o;
    logic         z;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         borrow_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;
  logic         zero;

  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  bit   bp_mode = 1'b0;
  exp_t q[$];
  int   dcyc[$];

  bit          held = 1'b0;
  logic [34:0] held_val;
  exp_t        mon_e;

  n_bit_cla_subtractor_pipeline #(.DATA_WID(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .zero       (zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    exp_t            e;
    longint          sa;
    longint          sb;
    longint          s;
    longint unsigned ua;
    longint unsigned ub;
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    e.d  = a - b - {31'd0, bi};
    e.b  = ua < (ub + {63'd0, bi});
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    s    = sa - sb - longint'({63'd0, bi});
    e.o  = (s != longint'($signed(e.d)));
    e.z  = (e.d == '0);
    return e;
  endfunction

  always @(negedge clock) begin
    cyc       = cyc + 1;
    out_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
  end

  always begin
    @(negedge clock);
    #2;
    if (!reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_value", 64'({diff, borrow_out, overflow, zero}), 64'(held_val));
      end
      chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
      held = 1'b0;
      if (out_valid && !out_ready) begin
        held     = 1'b1;
        held_val = {diff, borrow_out, overflow, zero};
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_output: got diff %0h, want no output", diff);
        end else begin
          mon_e = q.pop_front();
          chk("result", 64'({diff, borrow_out, overflow, zero}),
              64'({mon_e.d, mon_e.b, mon_e.o, mon_e.z}));
          dcyc.push_back(cyc);
        end
      end
    end
  end

  // Entered just after a falling edge; returns just after a falling edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int t    = 0;
    bit done = 1'b0;
    in_valid  = 1'b1;
    in1       = a;
    in2       = b;
    borrow_in = bi;
    while (!done) begin
      #4;
      if (in_ready) begin
        q.push_back(model(a, b, bi));
        done = 1'b1;
      end
      @(negedge clock);
      if (!done) begin
        t++;
        if (t > 200) begin
          n_vec++;
          n_miss++;
          $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want accept", t);
          done = 1'b1;
        end
      end
    end
    in_valid  = 1'b0;
    in1       = $urandom;
    in2       = $urandom;
    borrow_in = ($urandom_range(0, 1) == 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: got %0d pending results, want 0", q.size());
    end
  endtask

  initial begin
    int base;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    borrow_in = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clock);
    #1;
    chk("reset_state", 64'({out_valid, diff, borrow_out, overflow, zero}), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(negedge clock);

    // Reset mid-stream: in-flight ops are dropped and never reach the output.
    repeat (3) send($urandom, $urandom, ($urandom_range(0, 1) == 1));
    reset = 1'b0;
    #1;
    chk("midstream_reset", 64'({out_valid, diff, borrow_out, overflow, zero}), 64'd0);
    q.delete();
    @(negedge clock);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clock);
      #1;
      chk("post_reset_idle", 64'(out_valid), 64'd0);
    end
    @(negedge clock);

    send(32'h0000_0005, 32'h0000_0003, 1'b0);
    #1;
    chk("latency_one_edge", 64'(out_valid), 64'd0);
    @(negedge clock);
    #1;
    chk("latency_two_edges", 64'(out_valid), 64'd1);
    chk("five_minus_three", 64'({diff, borrow_out, overflow, zero}), {29'd0, 32'h0000_0002, 3'b000});
    @(negedge clock);

    send(32'h0000_0000, 32'h0000_0001, 1'b0);
    @(negedge clock);
    #1;
    chk("zero_minus_one", 64'({diff, borrow_out, overflow, zero}), {29'd0, 32'hFFFF_FFFF, 3'b100});
    @(negedge clock);

    send(32'h8000_0000, 32'h0000_0001, 1'b0);
    @(negedge clock);
    #1;
    chk("signed_overflow", 64'({diff, borrow_out, overflow, zero}), {29'd0, 32'h7FFF_FFFF, 3'b010});
    @(negedge clock);

    send(32'h1234_5678, 32'h1234_5677, 1'b1);
    @(negedge clock);
    #1;
    chk("zero_with_borrow_in", 64'({diff, borrow_out, overflow, zero}), {29'd0, 32'h0000_0000, 3'b001});
    @(negedge clock);

    send(32'h0000_0000, 32'h0000_0000, 1'b1);
    @(negedge clock);
    #1;
    chk("borrow_in_only", 64'({diff, borrow_out, overflow, zero}), {29'd0, 32'hFFFF_FFFF, 3'b100});
    @(negedge clock);

    // Backpressure with out_ready pattern 1,0,0.
    bp_mode = 1'b1;
    repeat (8) send($urandom, $urandom, ($urandom_range(0, 1) == 1));
    bp_mode = 1'b0;
    wait_drain();

    // Throughput: back-to-back with out_ready held high.
    base = dcyc.size();
    for (int i = 0; i < 100; i++) begin
      if (i == 50) send(32'h0000_FFFF, 32'hFFFF_0000, 1'b0);
      else         send($urandom, $urandom, ($urandom_range(0, 1) == 1));
    end
    wait_drain();
    chk("tput_count", 64'(dcyc.size() - base), 64'd100);
    if (dcyc.size() - base >= 100)
      chk("tput_span", 64'(dcyc[base+99] - dcyc[base]), 64'd99);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
